// File: rtl/pe_pkg.sv
// Shared PE definitions: divider FSM states, the clog2 helper and width helpers.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } div_state_e;

  localparam int unsigned DEF_BITWIDTH = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    if (value <= 1) return 0;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned dividend_w(input int unsigned bw);
    return 2 * bw;
  endfunction

  function automatic int unsigned count_w(input int unsigned bw);
    return clog2(2 * bw) + 1;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_restore_step #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic [BITWIDTH:0]   rem_i,
  input  logic                bit_i,
  input  logic [BITWIDTH-1:0] dvs_i,
  output logic [BITWIDTH:0]   rem_o,
  output logic                q_o
);

  logic [BITWIDTH+1:0] shifted;
  logic [BITWIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, dvs_i};
    q_o     = ~trial[BITWIDTH+1];
    rem_o   = q_o ? trial[BITWIDTH:0] : shifted[BITWIDTH:0];
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed restoring divider: 2W-bit dividend / W-bit divisor,
// truncating quotient and dividend-signed remainder, fixed 2W+2 cycle latency.
module signed_divider
  import pe_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in_valid,
  input  logic [2*BITWIDTH-1:0]   dividend,
  input  logic [BITWIDTH-1:0]     divisor,
  output logic                    in_ready,
  output logic                    data_out_valid,
  output logic [2*BITWIDTH-1:0]   quotient,
  output logic [BITWIDTH-1:0]     remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int unsigned W  = BITWIDTH;
  localparam int unsigned DW = dividend_w(BITWIDTH);
  localparam int unsigned CW = count_w(BITWIDTH);

  div_state_e          state_q;
  logic [DW-1:0]       dvd_q;
  logic [W-1:0]        dvs_q;
  logic [W:0]          rem_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_n_q, neg_d_q, zero_q, ovf_q;
  logic [DW-1:0]       quo_q, quo_d;
  logic [W-1:0]        rem_out_q, rem_d;
  logic                dz_q, of_q, valid_q;
  logic [W:0]          step_rem;
  logic                step_q;

  div_restore_step #(.BITWIDTH(W)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // dvd_q doubles as the quotient register: dividend bits shift out the top
  // while quotient bits shift in at the bottom.
  always_comb begin
    quo_d = (neg_n_q ^ neg_d_q) ? -dvd_q : dvd_q;
    rem_d = neg_n_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    if (zero_q) begin
      quo_d = '1;
      rem_d = '0;
    end else if (ovf_q) begin
      quo_d = {1'b1, {(DW-1){1'b0}}};
      rem_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_n_q   <= 1'b0;
      neg_d_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      quo_q     <= '0;
      rem_out_q <= '0;
      dz_q      <= 1'b0;
      of_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_in_valid) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            neg_n_q <= dividend[DW-1];
            neg_d_q <= divisor[W-1];
            zero_q  <= (divisor == '0);
            ovf_q   <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
            state_q <= PREP;
          end
        end
        PREP: begin
          if (neg_n_q) dvd_q <= -dvd_q;
          if (neg_d_q) dvs_q <= -dvs_q;
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[DW-2:0], step_q};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_q <= FIX;
        end
        FIX: begin
          quo_q     <= quo_d;
          rem_out_q <= rem_d;
          dz_q      <= zero_q;
          of_q      <= ovf_q & ~zero_q;
          valid_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign data_out_valid = valid_q;
  assign quotient       = quo_q;
  assign remainder      = rem_out_q;
  assign div_by_zero    = dz_q;
  assign overflow       = of_q;

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed divider, the inverse datapath of the PE's `signed_multiplier`. It takes a 2·BITWIDTH-bit signed dividend (a product-width value) and a BITWIDTH-bit signed divisor, and returns a truncated quotient and remainder. It uses restoring division, one quotient bit per clock. It sits on the PE fast clock beside the multiplier and recovers operands from products during self-check and normalisation.

## Interface
- `BITWIDTH`, 8, operand width. The dividend is 2·BITWIDTH bits.
- `clk`  in  1  fast PE clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `data_in_valid`  in  1  request; sampled only while `in_ready`=1.
- `dividend`  in  2·BITWIDTH  signed dividend.
- `divisor`  in  BITWIDTH  signed divisor.
- `in_ready`  out  1  high iff FSM is in IDLE.
- `data_out_valid`  out  1  one-cycle pulse; result ports are valid.
- `quotient`  out  2·BITWIDTH  signed quotient.
- `remainder`  out  BITWIDTH  signed remainder.
- `div_by_zero`  out  1  divisor was 0; qualified by `data_out_valid`.
- `overflow`  out  1  dividend = −2^(2W−1) and divisor = −1; qualified by `data_out_valid`.

## Operation
- FSM states and transitions:
  - IDLE → PREP on `data_in_valid`.
  - PREP → CALC.
  - CALC stays for 2·BITWIDTH cycles, then → FIX.
  - FIX → IDLE.
- IDLE: on `data_in_valid`, register `dividend`, `divisor` and their signs. `data_in_valid` is ignored in any other state; no queueing.
- PREP: form magnitudes.
  - |dividend| is 2W-bit unsigned; −2^(2W−1) maps to 2^(2W−1).
  - |divisor| is W-bit unsigned; −2^(W−1) maps to 2^(W−1).
  - Clear the W+1-bit partial remainder and the step counter (width clog2(2W)+1).
- CALC, each cycle:
  - Shift the partial remainder left by one, taking in the next dividend MSB.
  - Trial-subtract |divisor|. If the result is ≥0, keep it and set quotient bit 1; otherwise restore and set 0.
  - Counter increments; leave on count 2W−1.
- FIX: negate the quotient if the operand signs differ; the remainder takes the dividend's sign (C semantics, truncation toward zero). Then register the outputs and assert `data_out_valid` for exactly one cycle.
- Divide by zero: full fixed-latency pass. Force `quotient` = all-ones, `remainder` = 0, `div_by_zero` = 1, `overflow` = 0.
- Overflow: `quotient` = −2^(2W−1) (two's-complement wrap), `remainder` = 0, `overflow` = 1.
- Result ports hold their value until the next FIX. Flags are cleared in every FIX where they do not apply.
- Reset (`rst`=0 at an edge), including mid-CALC:
  - State → IDLE; abort the operation; no `data_out_valid`.
  - `in_ready`=1 after reset.
  - `data_out_valid`, `quotient`, `remainder`, `div_by_zero` and `overflow` = 0.

## Timing
- Request accepted at edge 0 (`in_ready`=1 and `data_in_valid`=1).
- Edge 1: PREP done.
- Edges 2…2W+1: CALC iterations.
- Edge 2W+2: FIX registers outputs. `data_out_valid`=1 during the following cycle, i.e. latency 2W+2 = 18 cycles for W=8. Latency is independent of operand values, including zero and overflow cases.
- `in_ready` rises at edge 2W+2, in the same cycle as `data_out_valid`. A new request may be accepted at edge 2W+3, giving back-to-back throughput of one op per 2W+3 cycles.
- `data_out_valid` and the flags are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `pe_pkg` holds:
  - FSM state localparams: IDLE, PREP, CALC, FIX.
  - The `clog2` function (same body as the PE benches).
  - Width helper constants derived from BITWIDTH.
- One sub-module is natural: `div_restore_step`. It is combinational and performs one shift/trial-subtract/select. Inputs: partial remainder, next dividend bit, |divisor|. Outputs: new remainder, quotient bit.
- FSM, counter, abs/sign fix and output registers stay in `signed_divider`.

## Test plan
All cases use BITWIDTH=8.
- 1000 / 7 → `quotient`=142, `remainder`=6, `data_out_valid` exactly 18 cycles after the accept edge, 1-cycle wide.
- Sign cases:
  - −1000 / 7 → −142, −6.
  - 1000 / −7 → −142, 6.
  - −1000 / −7 → 142, −6.
  - −16384 / −128 → 128, 0.
- Special cases:
  - −32768 / −1 → `quotient`=−32768, `overflow`=1.
  - 123 / 0 → `quotient`=16'hFFFF, `remainder`=0, `div_by_zero`=1, latency still 18.
- Round-trip sweep against the multiplier: for every a in −128…127 and b ≠ 0, (a·b)/b → `quotient`=a, `remainder`=0, both flags 0.
- Handshake:
  - `data_in_valid` pulsed during CALC is ignored; the result matches the first request only.
  - A new request on the `data_out_valid` cycle is accepted at the next edge and its result arrives 18 cycles later.
- `rst`=0 for one edge mid-CALC → no `data_out_valid`, all outputs 0, `in_ready`=1; the next request completes correctly.
